// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled,
`endif
  output logic        fetch_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [31:0] WORD_LIMIT = 32'(IMEM_WORDS);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid_n;
  logic [31:0] instr_n, ifid_pc_n, pc_plus4_n;
  logic [31:0] redirect_target;
  logic        out_of_range;

  assign redirect_target = redirect_pc & ~32'd3;
  assign out_of_range    = {2'b00, pc[31:2]} >= WORD_LIMIT;
  assign imem_addr       = {2'b00, pc[31:2]};
  assign fetch_done      = (state == S_HALT);

  // NOTE: every signal gets a hold default before the case so no latch is inferred.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    valid_n    = ifid_valid;
    instr_n    = ifid_instr;
    ifid_pc_n  = ifid_pc;
    pc_plus4_n = ifid_pc_plus4;
    case (state)
      S_IDLE: begin
        if (redirect_valid) pc_n = redirect_target;
        if (start)          state_n = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          pc_n    = redirect_target;
          valid_n = 1'b0;
          instr_n = '0;
        end else if (out_of_range) begin
          // Fell off the end of the program: drain IF/ID and wait for a late redirect.
          valid_n = 1'b0;
          instr_n = '0;
          state_n = S_HALT;
        end else if (stall) begin
          if (flush) begin
            valid_n = 1'b0;
            instr_n = '0;
          end
        end else begin
          valid_n    = !flush;
          instr_n    = flush ? 32'd0 : imem_data;
          ifid_pc_n  = pc;
          pc_plus4_n = pc + 32'd4;
          pc_n       = pc + 32'd4;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_n    = redirect_target;
          state_n = S_RUN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      ifid_valid    <= valid_n;
      ifid_instr    <= instr_n;
      ifid_pc       <= ifid_pc_n;
      ifid_pc_plus4 <= pc_plus4_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetched_inc, stalled_inc;

  assign fetched_inc = (state == S_RUN) && !redirect_valid && !out_of_range && !stall && !flush;
  assign stalled_inc = (state == S_RUN) && stall && !redirect_valid;

  // Both counters saturate rather than wrap so long runs never read as small.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stalled <= '0;
    end else begin
      if (fetched_inc && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      if (stalled_inc && (perf_stalled != 32'hFFFF_FFFF)) perf_stalled <= perf_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model queues expected outputs per cycle,
// a monitor pops and compares them after every rising edge.
module tb_fetch_stage;
  localparam int          WORDS  = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid, fetch_done;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stalled;
`endif

  always #5 clk = ~clk;

  logic [31:0] mem [WORDS];

  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr < 32'(WORDS)) imem_data = mem[imem_addr[3:0]];
  end

  fetch_stage #(.RESET_PC(RST_PC), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_stalled(perf_stalled),
`endif
    .fetch_done(fetch_done)
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc, pc4, addr;
    logic        done;
    logic [31:0] n_fetched, n_stalled;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: program-level view of the fetch unit.
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc;
  exp_t        m_out;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = RST_PC;
    m_out   = '{valid: 1'b0, instr: 32'd0, pc: 32'd0, pc4: 32'd0, addr: 32'd0,
                done: 1'b0, n_fetched: 32'd0, n_stalled: 32'd0};
  endtask

  task automatic step(input logic r, input logic s, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rpc);
    int word;
    @(negedge clk);
    reset = r; start = s; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    word = int'(m_pc / 4);
    if (r) begin
      model_reset();
    end else if (m_mode == M_IDLE) begin
      if (rv) m_pc = rpc - (rpc % 4);
      if (s)  m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (rv) begin
        m_pc   = rpc - (rpc % 4);
        m_mode = M_RUN;
      end
    end else begin
      if (st && !rv) m_out.n_stalled++;
      if (rv) begin
        m_pc = rpc - (rpc % 4);
        m_out.valid = 1'b0;
        m_out.instr = 32'd0;
      end else if (word >= WORDS) begin
        m_out.valid = 1'b0;
        m_out.instr = 32'd0;
        m_mode      = M_HALT;
      end else if (st) begin
        if (fl) begin
          m_out.valid = 1'b0;
          m_out.instr = 32'd0;
        end
      end else begin
        m_out.valid = !fl;
        m_out.instr = fl ? 32'd0 : mem[word];
        m_out.pc    = m_pc;
        m_out.pc4   = m_pc + 4;
        m_pc        = m_pc + 4;
        if (!fl) m_out.n_fetched++;
      end
    end
    m_out.addr = m_pc / 4;
    m_out.done = (m_mode == M_HALT);
    exp_q.push_back(m_out);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, mon_e.valid});
      check("fetch_done", {31'd0, fetch_done}, {31'd0, mon_e.done});
      check("imem_addr", imem_addr, mon_e.addr);
      check("ifid_instr", ifid_instr, mon_e.instr);
      check("ifid_pc", ifid_pc, mon_e.pc);
      check("ifid_pc_plus4", ifid_pc_plus4, mon_e.pc4);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, mon_e.n_fetched);
      check("perf_stalled", perf_stalled, mon_e.n_stalled);
`endif
    end
  end

  initial begin
    logic        r, s, st, fl, rv;
    logic [31:0] rpc;
    model_reset();
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h2000_0001 + 32'(i);

    // Straight-line run to fall-off, then a late redirect out of HALT.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    nop(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    nop(20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0004);
    nop(3);

    // Stall hold, flush, redirect during stall, then reset mid-run.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    nop(3);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    nop(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    nop(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_001E);
    nop(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    nop(3);

    // Randomised phase with fresh program contents.
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 8);
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 15);
      rv  = ($urandom_range(0, 99) < 8);
      rpc = 32'($urandom_range(0, (WORDS + 2) * 4 - 1));
      step(r, s, st, fl, rv, rpc);
    end
    nop(2);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
